// File: rtl/vending_machine_multi_if.sv
// Coin/keypad front-end and dispenser/coin-return bundle for vending_machine_multi.
// The front-end drives through master; the vending core connects as slave.
interface vending_machine_multi_if #(
  parameter int ITEM_W   = 4,
  parameter int PRICE_W  = 4,
  parameter int CREDIT_W = 5
);
  logic                five_in;
  logic                ten_in;
  logic                twenty_in;
  logic [ITEM_W-1:0]   item;
  logic                buy;
  logic                cancel;
  logic                prog_we;
  logic [ITEM_W-1:0]   prog_addr;
  logic [PRICE_W-1:0]  prog_price;
  logic                dispense;
  logic                five_out;
  logic                ten_out;
  logic                coin_reject;
  logic                sold_out;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output five_in, ten_in, twenty_in, item, buy, cancel, prog_we, prog_addr, prog_price,
    input  dispense, five_out, ten_out, coin_reject, sold_out, busy, credit
  );

  modport slave (
    input  five_in, ten_in, twenty_in, item, buy, cancel, prog_we, prog_addr, prog_price,
    output dispense, five_out, ten_out, coin_reject, sold_out, busy, credit
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-item vending core: coin credit, price table, per-item stock, serial ten/five change.
// Define VM_REFUND_EN to let cancel return the collected credit without a purchase.
module vending_machine_multi #(
  parameter int NUM_ITEMS     = 16,
  parameter int PRICE_W       = 4,
  parameter int CREDIT_W      = 5,
  parameter int MAX_CREDIT    = 16,
  parameter int DEFAULT_PRICE = 3,
  parameter int STOCK_W       = 4,
  parameter int STOCK_INIT    = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  vending_machine_multi_if.slave bus
);
  localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int SUM_W  = CREDIT_W + 1;
  localparam logic [ITEM_W:0] ITEM_LIM = (ITEM_W + 1)'(NUM_ITEMS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic                r_five;
  logic                r_ten;
  logic                r_reject;
  logic                r_sold;
  logic                r_busy;
  logic [PRICE_W-1:0]  r_price [NUM_ITEMS];
  logic [STOCK_W-1:0]  r_stock [NUM_ITEMS];

  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_dispense_nxt;
  logic                w_five_nxt;
  logic                w_ten_nxt;
  logic                w_reject_nxt;
  logic                w_sold_nxt;
  logic                w_stock_dec;
  logic                w_prog_wr;
  logic                w_item_ok;
  logic                w_prog_ok;
  logic                w_coin_any;
  logic                w_cancel_req;
  logic                w_chg_ten;
  logic [CREDIT_W-1:0] w_chg_credit;
  logic [SUM_W-1:0]    w_credit_ext;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_coin_total;
  logic [SUM_W-1:0]    w_price_ext;
  logic [STOCK_W-1:0]  w_stock_sel;
  logic [PRICE_W-1:0]  w_price_sel;

  assign w_item_ok    = ({1'b0, bus.item} < ITEM_LIM);
  assign w_prog_ok    = ({1'b0, bus.prog_addr} < ITEM_LIM);
  assign w_stock_sel  = w_item_ok ? r_stock[bus.item] : {STOCK_W{1'b0}};
  assign w_price_sel  = w_item_ok ? r_price[bus.item] : {PRICE_W{1'b0}};
  assign w_price_ext  = SUM_W'(w_price_sel);
  assign w_credit_ext = {1'b0, r_credit};
  assign w_coin_any   = bus.five_in | bus.ten_in | bus.twenty_in;
  assign w_sum        = SUM_W'(bus.five_in) + (SUM_W'(bus.ten_in) << 1) + (SUM_W'(bus.twenty_in) << 2);
  assign w_coin_total = w_credit_ext + w_sum;
  assign w_chg_ten    = (r_credit >= CREDIT_W'(2));
  assign w_chg_credit = w_chg_ten ? (r_credit - CREDIT_W'(2)) : (r_credit - CREDIT_W'(1));
  assign w_prog_wr    = bus.prog_we & w_prog_ok & ((r_state == S_IDLE) | (r_state == S_COLLECT));

`ifdef VM_REFUND_EN
  assign w_cancel_req = bus.cancel & (r_state == S_COLLECT);
`else
  logic w_unused_cancel;
  assign w_unused_cancel = bus.cancel;
  assign w_cancel_req    = 1'b0;
`endif

  // Next-state, next-credit and next-pulse decode
  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_dispense_nxt = 1'b0;
    w_five_nxt     = 1'b0;
    w_ten_nxt      = 1'b0;
    w_reject_nxt   = 1'b0;
    w_sold_nxt     = 1'b0;
    w_stock_dec    = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (bus.buy) begin
          w_reject_nxt = w_coin_any;
          if (!w_item_ok || (w_stock_sel == {STOCK_W{1'b0}})) begin
            w_sold_nxt = 1'b1;
          end else if (w_credit_ext >= w_price_ext) begin
            w_dispense_nxt = 1'b1;
            w_stock_dec    = 1'b1;
            w_credit_nxt   = r_credit - CREDIT_W'(w_price_ext);
            w_state_nxt    = S_DISPENSE;
          end else begin
            w_sold_nxt = 1'b0;
          end
        end else if (w_cancel_req) begin
          // Refund enters CHANGE with its first coin already on the way out
          w_reject_nxt = w_coin_any;
          w_ten_nxt    = w_chg_ten;
          w_five_nxt   = ~w_chg_ten;
          w_credit_nxt = w_chg_credit;
          w_state_nxt  = S_CHANGE;
        end else if (w_coin_any) begin
          if (w_coin_total <= SUM_W'(MAX_CREDIT)) begin
            w_credit_nxt = CREDIT_W'(w_coin_total);
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else begin
          w_credit_nxt = r_credit;
        end
        if ((w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE)) begin
          w_state_nxt = w_state_nxt;
        end else begin
          w_state_nxt = (w_credit_nxt == {CREDIT_W{1'b0}}) ? S_IDLE : S_COLLECT;
        end
      end
      S_DISPENSE, S_CHANGE: begin
        w_reject_nxt = w_coin_any;
        if (r_credit != {CREDIT_W{1'b0}}) begin
          w_ten_nxt    = w_chg_ten;
          w_five_nxt   = ~w_chg_ten;
          w_credit_nxt = w_chg_credit;
          w_state_nxt  = S_CHANGE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_credit_nxt = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // State, credit and registered output pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_credit   <= {CREDIT_W{1'b0}};
      r_dispense <= 1'b0;
      r_five     <= 1'b0;
      r_ten      <= 1'b0;
      r_reject   <= 1'b0;
      r_sold     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_dispense <= w_dispense_nxt;
      r_five     <= w_five_nxt;
      r_ten      <= w_ten_nxt;
      r_reject   <= w_reject_nxt;
      r_sold     <= w_sold_nxt;
      r_busy     <= (w_state_nxt == S_DISPENSE) | (w_state_nxt == S_CHANGE);
    end
  end

  // Price table and stock counters; a programming write overrides a same-cycle vend decrement
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        r_price[i] <= PRICE_W'(DEFAULT_PRICE);
        r_stock[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      if (w_stock_dec) begin
        r_stock[bus.item] <= r_stock[bus.item] - STOCK_W'(1);
      end
      if (w_prog_wr) begin
        r_price[bus.prog_addr] <= bus.prog_price;
        r_stock[bus.prog_addr] <= STOCK_W'(STOCK_INIT);
      end
    end
  end

  assign bus.dispense    = r_dispense;
  assign bus.five_out    = r_five;
  assign bus.ten_out     = r_ten;
  assign bus.coin_reject = r_reject;
  assign bus.sold_out    = r_sold;
  assign bus.busy        = r_busy;
  assign bus.credit      = r_credit;
endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-item vending FSM. Tracks credit from three coin denominations and holds a programmable price table plus per-item stock counters. Supports buy strobes and returns change serially as ten/five pulses. Sits between the coin/keypad front-end and the dispenser/coin-return actuators.

Parameters:
NUM_ITEMS, 16, number of selectable items (item index width ITEM_W = clog2(NUM_ITEMS), min 1)
PRICE_W, 4, price width in 5-unit steps (price 3 = 15)
CREDIT_W, 5, credit register width in 5-unit steps
MAX_CREDIT, 16, credit ceiling in units; must be < 2**CREDIT_W
DEFAULT_PRICE, 3, reset price of every item, in units
STOCK_W, 4, stock counter width
STOCK_INIT, 5, stock loaded at reset and on programming

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
five_in  in  1  5 coin (1 unit), one-cycle pulse
ten_in  in  1  10 coin (2 units)
twenty_in  in  1  20 coin (4 units)
item  in  ITEM_W  item select, sampled with buy
buy  in  1  purchase request strobe
cancel  in  1  refund request (see Optional Feature)
prog_we  in  1  price/restock write strobe
prog_addr  in  ITEM_W  item to program
prog_price  in  PRICE_W  new price in units
dispense  out  1  one-cycle vend pulse
five_out  out  1  one-cycle pulse returning one 5 coin
ten_out  out  1  one-cycle pulse returning one 10 coin
coin_reject  out  1  one-cycle pulse, coin(s) refused
sold_out  out  1  one-cycle pulse, buy refused for zero stock
busy  out  1  high in DISPENSE/CHANGE
credit  out  CREDIT_W  current credit in units

Behaviour:
- Reset (reset=0, async): state IDLE; credit=0; all pulse outputs=0; busy=0; every price=DEFAULT_PRICE; every stock=STOCK_INIT.
- States: IDLE (credit=0), COLLECT (credit>0), DISPENSE, CHANGE.
- Coins: in IDLE/COLLECT, sum = five_in*1 + ten_in*2 + twenty_in*4. Simultaneous coins are summed. If credit+sum <= MAX_CREDIT, credit += sum next edge; otherwise credit is unchanged and coin_reject=1 for one cycle (whole group refused). In DISPENSE/CHANGE any coin gives coin_reject.
- Buy: in IDLE/COLLECT with buy=1, priority over coins in the same cycle (coins that cycle are rejected):
  - stock[item]==0: sold_out pulse next cycle, no state change.
  - credit < price[item]: ignored, no pulse.
  - otherwise: next cycle state DISPENSE, dispense=1, credit -= price, stock[item] -= 1.
- Price 0 is legal: vends with credit 0.
- DISPENSE lasts one cycle. Then CHANGE if credit>0, else IDLE.
- CHANGE: one pulse per cycle. If credit>=2, ten_out=1 and credit-=2; else five_out=1 and credit-=1. Go to IDLE the cycle after credit reaches 0.
- Latency: buy sampled at edge k -> dispense high cycle k..k+1; first change pulse the following cycle.
- prog_we: accepted only when busy=0. Writes price[prog_addr]=prog_price and stock[prog_addr]=STOCK_INIT. Ignored while busy. A buy in the same cycle uses the old price.
- Out-of-range item or prog_addr (>= NUM_ITEMS) is treated as sold out and the write is ignored.
- busy = (state==DISPENSE || state==CHANGE). All outputs are registered.

Optional Feature:
VM_REFUND_EN
- Defined: cancel=1 in COLLECT (with no buy that cycle) enters CHANGE directly with no dispense; the full credit is returned via the same ten/five sequence. cancel in IDLE/DISPENSE/CHANGE is ignored.
- Undefined: cancel is ignored entirely; credit is held until a purchase.

Test Plan:
1. Reset, five_in then ten_in, buy item=4 -> credit 1 then 3, dispense one cycle, no change pulses, stock[4]=4, back to IDLE.
2. twenty_in, ten_in (credit 6), buy item=4 price 3 -> dispense, then ten_out one cycle, five_out one cycle, credit 0.
3. prog_we addr=2 price=1 while STOCK_INIT=5; buy item 2 six times with credit 1 each -> five dispenses, sixth gives sold_out.
4. MAX_CREDIT=8: twenty_in, twenty_in, five_in -> credit 8, third coin coin_reject; five_in+ten_in in same cycle from 0 -> credit 3.
5. Credit 6, buy price 3, assert reset low during CHANGE -> all outputs 0 immediately, credit 0, prices and stock restored to defaults.
6. VM_REFUND_EN defined, credit 5, cancel -> ten_out, ten_out, five_out, no dispense. Undefined -> credit stays 5.
